imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shared, parametrised instruction memory serving NUM_CORES cores from one single-ported storage array. Each core has its own request/grant/valid read channel; a round-robin arbiter picks one read per cycle, and every other core requesting the identical address that cycle is served by the same access. A separate loader write port fills program memory at run time and has absolute priority over reads. The block sits between the per-core fetch units and program storage in the multi-core processor.

## Interface
- DATA_W, 16, instruction word width
- ADDR_W, 16, address width per port
- DEPTH, 65536, number of words; must be ≤ 2^ADDR_W
- NUM_CORES, 4, number of read channels; ≥ 1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  loader write strobe
- wr_addr  in  ADDR_W  loader write address
- wr_data  in  DATA_W  loader write data
- rd_req  in  NUM_CORES  per-core read request, bit i = core i
- rd_addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
- rd_gnt  out  NUM_CORES  combinational grant, same cycle as the accepted request
- rd_valid  out  NUM_CORES  registered one-cycle pulse; rd_data for that core is new
- rd_data  out  NUM_CORES*DATA_W  registered per-core read data, core i at [i*DATA_W +: DATA_W]

## Operation
- Storage: DEPTH × DATA_W array. Contents are not cleared by rst and are undefined until written.
- Loader priority: when wr_en=1, the write is performed and rd_gnt=0 for all cores. The RR pointer is unchanged.
- Arbitration, when wr_en=0:
  - ptr holds the index of the last winner.
  - Winner w = first i with rd_req[i]=1, scanning ptr+1, ptr+2, … modulo NUM_CORES.
- Address sharing: every core j with rd_req[j]=1 and rd_addr[j]==rd_addr[w] is also granted. rd_gnt is the set of these cores.
- Pointer update: ptr ← w only when some grant occurs. Sharing cores do not move ptr.
- Read: on the next edge, rd_data[j] ← mem[rd_addr[w]] and rd_valid[j] ← 1 for each granted j. Non-granted cores get rd_valid=0, and their rd_data holds its previous value.
- Out-of-range addresses (addr ≥ DEPTH):
  - A read returns 0 and is still granted and valid.
  - A write is dropped.
- Cores hold rd_req and rd_addr stable until they see rd_gnt. Deasserting rd_req before grant is allowed; the request is then simply not served.
- A core may re-request in the cycle after its grant, so back-to-back reads are allowed.

## Timing
- Reset values: ptr = NUM_CORES-1 (core 0 has top priority first), rd_valid = 0, rd_data = 0 for all cores. rd_gnt is 0 while rst=1.
- Read latency: 1 cycle, from the grant cycle to rd_valid/rd_data.
- Throughput: one distinct address per cycle. N cores requesting the same address are all served in 1 cycle.
- Starvation bound: with wr_en=0, a continuously requesting core is granted within NUM_CORES cycles.
- Write then read of the same address:
  - Write in cycle t, read granted in t+1: the read returns the new data.
  - No read is granted in cycle t itself.
- rst asserted mid-operation: outputs clear immediately (asynchronous). A read granted in the cycle before reset produces no rd_valid. Memory contents are retained.
- NUM_CORES=1: the arbiter degenerates to rd_gnt = rd_req & ~wr_en.

## Test plan
- Reset/load/read:
  - Release rst, write mem[5]=0x0007, mem[6]=0x0020.
  - Core 0 reads addr 5, then 6 back-to-back.
  - Expect gnt in cycles t and t+1, then rd_valid[0] with data 0x0007 and 0x0020 at t+1 and t+2.
- Round-robin (NUM_CORES=4):
  - All cores hold rd_req=1 with distinct addresses 0,1,2,3 holding 10,11,12,13.
  - Expect grants in order core 0,1,2,3,0, one per cycle, each core's rd_data matching its word.
- Address sharing:
  - Cores 1 and 3 request addr 40, core 2 requests addr 41, ptr=0.
  - Expect cores 1 and 3 granted together in the same cycle, both rd_valid with mem[40].
  - Core 2 granted the next cycle.
- Loader priority:
  - wr_en=1 to addr 9 (0x002D) while core 0 requests addr 9.
  - Expect no grant that cycle.
  - Expect a grant in the next cycle, with rd_data=0x002D one cycle after that.
- Out of range (DEPTH=64):
  - Write addr 100 with 0xFFFF, then read addr 100 and addr 36 (=100 mod 64).
  - Expect addr 100 to read 0, with rd_valid=1.
  - Expect addr 36 to be unchanged.
- Async reset mid-read:
  - Assert rst between the grant edge and the data edge.
  - Expect rd_valid=0 and rd_data=0 immediately, then ptr=3 behaviour after release (core 0 wins first).
  - Expect previously loaded words to still read correctly.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: one single-ported instruction store shared by NUM_CORES
// fetch channels. A round-robin arbiter picks one read address per cycle
// and every requester of that same address rides along on the access.
// The loader write port always wins over reads. Read data and valid are
// registered per core with a one-cycle latency.
module imem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 65536,
    parameter int NUM_CORES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [NUM_CORES-1:0]          rd_req,
    input  logic [NUM_CORES*ADDR_W-1:0]   rd_addr,
    output logic [NUM_CORES-1:0]          rd_gnt,
    output logic [NUM_CORES-1:0]          rd_valid,
    output logic [NUM_CORES*DATA_W-1:0]   rd_data
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage; deliberately not reset so program images survive rst.
    logic [DATA_W-1:0] mem [DEPTH];

    // Round-robin pointer: index of the most recent winning core.
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [NUM_CORES-1:0]        rd_valid_q, rd_valid_d;
    logic [NUM_CORES*DATA_W-1:0] rd_data_q, rd_data_d;

    logic [ADDR_W-1:0] addr_a [NUM_CORES];
    logic              found;
    logic [PTR_W-1:0]  win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] rd_word;

    // Addresses at or beyond DEPTH have no backing storage.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    // Core index k positions after base, wrapping at NUM_CORES.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_CORES;
        return s[PTR_W-1:0];
    endfunction

    // Split the flat address bus into one address per core.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            addr_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Pick the winner: first requester after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!found && rd_req[rr_idx(ptr_q, k)]) begin
                found = 1'b1;
                win   = rr_idx(ptr_q, k);
            end
        end
        win_addr = addr_a[win];
        rd_word  = in_range(win_addr) ? mem[win_addr[IDX_W-1:0]] : '0;
    end

    // Grant the winner plus every requester sharing its address; loader and reset block all reads.
    always_comb begin
        rd_gnt = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            rd_gnt[j] = !rst && !wr_en && found && rd_req[j] && (addr_a[j] == win_addr);
        end
    end

    // Next-state: pointer follows the winner only, granted cores capture the shared word.
    always_comb begin
        ptr_d      = ptr_q;
        rd_valid_d = rd_gnt;
        rd_data_d  = rd_data_q;
        if (|rd_gnt) begin
            ptr_d = win;
        end
        for (int j = 0; j < NUM_CORES; j++) begin
            if (rd_gnt[j]) begin
                rd_data_d[j*DATA_W +: DATA_W] = rd_word;
            end
        end
    end

    // Control and output registers; reset makes core 0 the first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= PTR_W'(NUM_CORES - 1);
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Loader write; writes to addresses without storage are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en && in_range(wr_addr)) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios followed by randomized
// traffic, checked by a scoreboard fed from a behavioural model.
module tb_imem_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 64;
    localparam int NC    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [NC-1:0]     rd_req = '1;
    logic [NC*AW-1:0]  rd_addr = '0;
    logic [NC-1:0]     rd_gnt;
    logic [NC-1:0]     rd_valid;
    logic [NC*DW-1:0]  rd_data;

    imem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_CORES(NC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            core;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr = NC - 1;
    logic [DW-1:0] exp_data [NC];
    logic [NC-1:0] mon_vm;
    exp_t          mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*AW-1:0] pk(input logic [AW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (int'(a) < DEPTH) return m_mem[int'(a)];
        return '0;
    endfunction

    // One clock cycle of stimulus; the model predicts grants and queues read results.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NC-1:0] req, input logic [NC*AW-1:0] addrs,
                        input int want, output logic [NC-1:0] gm);
        int w;
        logic [AW-1:0] aw;
        gm = '0;
        w  = -1;
        aw = '0;
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_req = req; rd_addr = addrs;
        #1;
        if (!we) begin
            for (int k = 1; k <= NC; k++) begin
                if (w < 0 && req[(m_ptr + k) % NC]) w = (m_ptr + k) % NC;
            end
            if (w >= 0) begin
                aw = addrs[w*AW +: AW];
                for (int j = 0; j < NC; j++) begin
                    if (req[j] && addrs[j*AW +: AW] == aw) gm[j] = 1'b1;
                end
                m_ptr = w;
            end
        end
        chk("gnt_model", rd_gnt, gm);
        if (want >= 0) chk("gnt_plan", rd_gnt, want);
        for (int j = 0; j < NC; j++) begin
            if (gm[j]) sbq.push_back('{due: cyc + 1, core: j, data: m_read(aw)});
        end
        if (we && int'(wa) < DEPTH) m_mem[int'(wa)] = wd;
    endtask

    // Monitor: compare valid and all data lanes against the scoreboard every cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            for (int j = 0; j < NC; j++) exp_data[j] = '0;
            chk("reset_valid", rd_valid, 0);
            chk("reset_data", rd_data, 0);
        end else begin
            mon_vm = '0;
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                mon_e = sbq.pop_front();
                mon_vm[mon_e.core] = 1'b1;
                exp_data[mon_e.core] = mon_e.data;
            end
            chk("rd_valid", rd_valid, mon_vm);
            for (int j = 0; j < NC; j++) begin
                chk($sformatf("rd_data[%0d]", j), rd_data[j*DW +: DW], exp_data[j]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NC-1:0] g;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [NC-1:0] pend;
        logic [AW-1:0] paddr [NC];
        int            waitc [NC];
        int            wants [5];

        // Reset state while every core requests.
        #7;
        chk("rst_gnt", rd_gnt, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_req = '0;

        for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), DW'($urandom), '0, '0, 0, g);
        for (int a = 0; a < 4; a++) step(1'b1, AW'(a), DW'(10 + a), '0, '0, 0, g);
        step(1'b1, 16'd5, 16'h0007, '0, '0, 0, g);
        step(1'b1, 16'd6, 16'h0020, '0, '0, 0, g);

        // Round robin across four distinct addresses.
        wants = '{1, 2, 4, 8, 1};
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 4'hF, pk(0, 1, 2, 3), wants[i], g);
        step(1'b0, '0, '0, '0, '0, 0, g);

        // Address sharing with ptr = 0.
        step(1'b0, '0, '0, 4'b1110, pk(0, 40, 41, 40), 4'b1010, g);
        step(1'b0, '0, '0, 4'b0100, pk(0, 40, 41, 40), 4'b0100, g);
        step(1'b0, '0, '0, '0, '0, 0, g);

        // Back-to-back reads by core 0.
        step(1'b0, '0, '0, 4'b0001, pk(5, 0, 0, 0), 1, g);
        step(1'b0, '0, '0, 4'b0001, pk(6, 0, 0, 0), 1, g);
        step(1'b0, '0, '0, '0, '0, 0, g);

        // Loader priority over a same-address read.
        step(1'b1, 16'd9, 16'h002D, 4'b0001, pk(9, 0, 0, 0), 0, g);
        step(1'b0, '0, '0, 4'b0001, pk(9, 0, 0, 0), 1, g);
        step(1'b0, '0, '0, '0, '0, 0, g);

        // Out-of-range write dropped, read returns zero, alias untouched.
        step(1'b1, 16'd100, 16'hFFFF, '0, '0, 0, g);
        step(1'b0, '0, '0, 4'b0001, pk(100, 0, 0, 0), 1, g);
        step(1'b0, '0, '0, 4'b0001, pk(36, 0, 0, 0), 1, g);

        // Async reset between grant edge and data edge.
        step(1'b0, '0, '0, 4'b0010, pk(0, 6, 0, 0), 4'b0010, g);
        @(posedge clk);
        #1;
        rd_req = 4'b0001; rd_addr = pk(5, 0, 0, 0);
        #1;
        chk("pre_rst_valid1", rd_valid[1], 1);
        chk("pre_rst_data1", rd_data[1*DW +: DW], 16'h0020);
        chk("pre_rst_gnt", rd_gnt, 4'b0001);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", rd_gnt, 0);
        chk("async_rst_valid", rd_valid, 0);
        chk("async_rst_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_req = '0;
        m_ptr = NC - 1;
        wants = '{1, 2, 4, 8, 1};
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 4'hF, pk(5, 6, 9, 36), wants[i], g);
        step(1'b0, '0, '0, '0, '0, 0, g);

        // Randomized traffic obeying the hold-until-grant protocol.
        pend = '0;
        for (int j = 0; j < NC; j++) begin
            paddr[j] = '0;
            waitc[j] = 0;
        end
        for (int it = 0; it < 400; it++) begin
            we = ($urandom_range(0, 7) == 0);
            wa = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(64, 70)) : AW'($urandom_range(0, 7));
            wd = DW'($urandom);
            for (int j = 0; j < NC; j++) begin
                if (pend[j]) begin
                    if ($urandom_range(0, 15) == 0) pend[j] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    pend[j] = 1'b1;
                    paddr[j] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(60, 70))
                                                           : AW'($urandom_range(0, 7));
                end
            end
            step(we, wa, wd, pend, pk(paddr[0], paddr[1], paddr[2], paddr[3]), -1, g);
            for (int j = 0; j < NC; j++) begin
                if (pend[j] && !we) waitc[j]++;
                if (g[j]) begin
                    chk("starvation", waitc[j] <= NC, 1);
                    waitc[j] = 0;
                    pend[j] = 1'b0;
                end else if (!pend[j]) begin
                    waitc[j] = 0;
                end
            end
        end

        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, 0, g);
        @(posedge clk);
        #1;
        chk("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
